// File: rtl/input_conditioner_if.sv
// Bus between the raw input bank and the CPU switch port: pad inputs and clear/mask
// controls in, debounced level plus sticky event bits and interrupt out.
interface input_conditioner_if #(
  parameter int N_IN = 8
);
  logic [N_IN-1:0] raw_in;
  logic            rd_clr;
  logic [N_IN-1:0] irq_mask;
  logic [N_IN-1:0] level;
  logic [N_IN-1:0] press;
  logic [N_IN-1:0] release_evt;  // "release" is a reserved word, hence the suffix
  logic            irq;

  // No valid/ready handshake on this bus: level and event bits are continuously
  // readable, and rd_clr is a level request that acts only on its rising edge.
  modport master (
    output raw_in, rd_clr, irq_mask,
    input  level, press, release_evt, irq
  );

  modport slave (
    input  raw_in, rd_clr, irq_mask,
    output level, press, release_evt, irq
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-latches a bank of raw push-button/switch inputs,
// exposing the stable level, sticky press/release events and a maskable press irq.
module input_conditioner #(
  parameter int N_IN       = 8,
  parameter int DEB_CYCLES = 625000,
  parameter int CNT_W      = 20
) (
  input  logic                clk_125mhz,
  input  logic                reset,
  input_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_IN-1:0]  s1_q, s1_d;
  logic [N_IN-1:0]  s2_q, s2_d;
  logic [N_IN-1:0]  lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic             rd_clr_q, rd_clr_d;
  logic [N_IN-1:0]  press_q, press_d;
  logic [N_IN-1:0]  release_q, release_d;
  logic [N_IN-1:0]  new_press;
  logic [N_IN-1:0]  new_release;
  logic             clr;

  always_comb begin
    s1_d        = bus.raw_in;
    s2_d        = s1_q;
    lvl_d       = lvl_q;
    cnt_d       = cnt_q;
    new_press   = '0;
    new_release = '0;
    rd_clr_d    = bus.rd_clr;

    // Any sample that agrees with the accepted level restarts qualification.
    for (int i = 0; i < N_IN; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DEB_LAST) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        lvl_d[i]       = s2_q[i];
        cnt_d[i]       = '0;
        new_press[i]   = s2_q[i];
        new_release[i] = ~s2_q[i];
      end
    end

    clr = bus.rd_clr & ~rd_clr_q;

    // Events qualifying in the clear cycle are kept; only older ones are dropped.
    if (clr) begin
      press_d   = new_press;
      release_d = new_release;
    end else begin
      press_d   = press_q | new_press;
      release_d = release_q | new_release;
    end
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      rd_clr_q  <= 1'b0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      lvl_q     <= lvl_d;
      rd_clr_q  <= rd_clr_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.level       = lvl_q;
  assign bus.press       = press_q;
  assign bus.release_evt = release_q;
  assign bus.irq         = |(press_q & bus.irq_mask);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEB_CYCLES=4: qualification latency,
// glitch rejection, irq masking, clear-on-read edge behaviour and mid-count reset.
module tb_input_conditioner;

  localparam int N_IN = 8;

  logic clk_125mhz = 1'b0;
  logic reset      = 1'b1;
  int   checks     = 0;
  int   errors     = 0;

  input_conditioner_if #(.N_IN(N_IN)) bus ();

  input_conditioner #(
    .N_IN      (N_IN),
    .DEB_CYCLES(4),
    .CNT_W     (3)
  ) dut (
    .clk_125mhz(clk_125mhz),
    .reset     (reset),
    .bus       (bus)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  // Advance one active edge, then settle 1 ns so outputs are sampled and inputs
  // are driven well away from the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_125mhz);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] lvl, input logic [7:0] prs,
                            input logic [7:0] rls);
    check({tag, "_level"},   32'(bus.level),       32'(lvl));
    check({tag, "_press"},   32'(bus.press),       32'(prs));
    check({tag, "_release"}, 32'(bus.release_evt), 32'(rls));
  endtask

  initial begin
    bus.raw_in   = 8'h00;
    bus.rd_clr   = 1'b0;
    bus.irq_mask = 8'h00;

    // Reset state
    tick(3);
    check_outs("in_reset", 8'h00, 8'h00, 8'h00);
    check("in_reset_irq", 32'(bus.irq), 32'd0);
    reset = 1'b0;
    tick(2);
    check_outs("after_reset", 8'h00, 8'h00, 8'h00);

    // Bit 0 rises: level and press appear at E6, not before
    bus.raw_in = 8'h01;
    tick(5);
    check_outs("b0_e5", 8'h00, 8'h00, 8'h00);
    tick(1);
    check_outs("b0_e6", 8'h01, 8'h01, 8'h00);

    // Three-cycle glitch on bit 3 is rejected
    bus.raw_in = 8'h09;
    tick(3);
    bus.raw_in = 8'h01;
    tick(8);
    check_outs("glitch_b3", 8'h01, 8'h01, 8'h00);

    // irq follows mask combinationally
    bus.irq_mask = 8'h01;
    #1;
    check("irq_mask_on", 32'(bus.irq), 32'd1);
    bus.irq_mask = 8'h00;
    #1;
    check("irq_mask_off", 32'(bus.irq), 32'd0);

    // Two-cycle rd_clr pulse clears one edge after its rise
    bus.rd_clr = 1'b1;
    tick(1);
    check("clr_pulse_e1", 32'(bus.press), 32'h00);
    tick(1);
    check("clr_pulse_e2", 32'(bus.press), 32'h00);
    bus.rd_clr = 1'b0;
    tick(1);

    // rd_clr held high: a later bit-1 press is not cleared
    bus.rd_clr = 1'b1;
    bus.raw_in = 8'h03;
    tick(6);
    check_outs("hold_clr_b1", 8'h03, 8'h02, 8'h00);
    tick(3);
    check("hold_clr_b1_kept", 32'(bus.press), 32'h02);
    bus.rd_clr = 1'b0;
    tick(1);

    // Bit 2 qualifies on the clear edge: new event survives, old one is dropped
    bus.raw_in = 8'h07;
    tick(5);
    check("b2_pre_clr", 32'(bus.press), 32'h02);
    bus.rd_clr = 1'b1;
    tick(1);
    check_outs("b2_on_clr", 8'h07, 8'h04, 8'h00);
    bus.rd_clr = 1'b0;
    tick(1);

    // Bit 7 rises, then falls: release at the sixth edge
    bus.raw_in = 8'h87;
    tick(6);
    check_outs("b7_rise", 8'h87, 8'h84, 8'h00);
    bus.irq_mask = 8'h80;
    #1;
    check("irq_b7", 32'(bus.irq), 32'd1);
    bus.raw_in = 8'h07;
    tick(5);
    check("b7_fall_e5", 32'(bus.release_evt), 32'h00);
    tick(1);
    check_outs("b7_fall_e6", 8'h07, 8'h84, 8'h80);

    // Reset at count 2 of a fresh qualification discards the count
    bus.raw_in = 8'h87;
    tick(4);
    check("b7_mid_level", 32'(bus.level), 32'h07);
    reset = 1'b1;
    #1;
    check_outs("mid_reset", 8'h00, 8'h00, 8'h00);
    check("mid_reset_irq", 32'(bus.irq), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check_outs("requal_e5", 8'h00, 8'h00, 8'h00);
    tick(1);
    check_outs("requal_e6", 8'h87, 8'h87, 8'h00);
    check("requal_irq", 32'(bus.irq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
